// File: rtl/shared_dmem_arbiter.sv
// Shared word-addressed data memory serving two cores' load/store ports through
// a two-state round-robin arbiter; one access per two cycles, ack is one cycle.
module shared_dmem_arbiter #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        a_req,
  input  logic        a_memwrite,
  input  logic [31:0] a_dataadr,
  input  logic [31:0] a_writedata,
  output logic [31:0] a_readdata,
  output logic        a_ack,

  input  logic        b_req,
  input  logic        b_memwrite,
  input  logic [31:0] b_dataadr,
  input  logic [31:0] b_writedata,
  output logic [31:0] b_readdata,
  output logic        b_ack
);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e      state_q;
  logic        gnt_q;   // 0 = A, 1 = B
  logic        last_q;  // last served core, same encoding

  logic [31:0] data [DEPTH];

  logic          grant;
  logic          grant_b;
  logic [AW-1:0] idx;
  logic [31:0]   wdata;
  logic          store;
  logic [31:0]   rdata;

  // Only the word-index bits of the byte address select a word.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{a_dataadr[31:AW+2], a_dataadr[1:0],
                             b_dataadr[31:AW+2], b_dataadr[1:0]};

  always_comb begin
    grant   = (state_q == StIdle) && (a_req || b_req);
    // On a tie the core that was not served last wins.
    grant_b = b_req && (!a_req || !last_q);
    idx     = grant_b ? b_dataadr[AW+1:2] : a_dataadr[AW+1:2];
    wdata   = grant_b ? b_writedata : a_writedata;
    store   = grant_b ? b_memwrite : a_memwrite;
    rdata   = data[idx];
  end

  // The memory shares the reset-qualified block so no store can land while rst is high;
  // its contents are deliberately left untouched by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      a_readdata <= 32'h0;
      b_readdata <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            state_q <= StAccess;
            gnt_q   <= grant_b;
            last_q  <= grant_b;
            if (store) begin
              data[idx] <= wdata;
            end
            if (grant_b) begin
              b_readdata <= store ? wdata : rdata;
            end else begin
              a_readdata <= store ? wdata : rdata;
            end
          end
        end
        StAccess: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign a_ack = (state_q == StAccess) && !gnt_q;
  assign b_ack = (state_q == StAccess) && gnt_q;

endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Directed bench for shared_dmem_arbiter: inputs change and outputs are sampled
// on the falling edge, expected values are hand-computed constants.
module tb_shared_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req;
  logic        a_memwrite;
  logic [31:0] a_dataadr;
  logic [31:0] a_writedata;
  logic [31:0] a_readdata;
  logic        a_ack;
  logic        b_req;
  logic        b_memwrite;
  logic [31:0] b_dataadr;
  logic [31:0] b_writedata;
  logic [31:0] b_readdata;
  logic        b_ack;

  int total_cnt;
  int fail_cnt;

  shared_dmem_arbiter #(
    .DEPTH(64),
    .AW   (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a_req      (a_req),
    .a_memwrite (a_memwrite),
    .a_dataadr  (a_dataadr),
    .a_writedata(a_writedata),
    .a_readdata (a_readdata),
    .a_ack      (a_ack),
    .b_req      (b_req),
    .b_memwrite (b_memwrite),
    .b_dataadr  (b_dataadr),
    .b_writedata(b_writedata),
    .b_readdata (b_readdata),
    .b_ack      (b_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_acks(input string tag, input logic exp_a, input logic exp_b);
    check({tag, "_a_ack"}, {31'h0, a_ack}, {31'h0, exp_a});
    check({tag, "_b_ack"}, {31'h0, b_ack}, {31'h0, exp_b});
  endtask

  initial begin
    logic exp_a;
    total_cnt   = 0;
    fail_cnt    = 0;

    // Reset held with both cores requesting loads of word 0.
    rst         = 1'b1;
    a_req       = 1'b1;
    b_req       = 1'b1;
    a_memwrite  = 1'b0;
    b_memwrite  = 1'b0;
    a_dataadr   = 32'h0;
    b_dataadr   = 32'h0;
    a_writedata = 32'h0;
    b_writedata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_acks("reset", 1'b0, 1'b0);
      check("reset_a_rd", a_readdata, 32'h0);
      check("reset_b_rd", b_readdata, 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    check_acks("rel_first", 1'b1, 1'b0);
    a_req = 1'b0;
    @(negedge clk);
    check_acks("rel_idle0", 1'b0, 1'b0);
    @(negedge clk);
    check_acks("rel_b", 1'b0, 1'b1);
    b_req = 1'b0;
    @(negedge clk);
    check_acks("rel_idle1", 1'b0, 1'b0);

    // Single store then load by A.
    a_req       = 1'b1;
    a_memwrite  = 1'b1;
    a_dataadr   = 32'h0;
    a_writedata = 32'h0001_0000;
    @(negedge clk);
    check_acks("st_a", 1'b1, 1'b0);
    a_req = 1'b0;
    @(negedge clk);
    check_acks("st_idle", 1'b0, 1'b0);
    check("st_mem0", dut.data[0], 32'h0001_0000);
    a_req      = 1'b1;
    a_memwrite = 1'b0;
    @(negedge clk);
    check_acks("ld_a", 1'b1, 1'b0);
    check("ld_a_rd", a_readdata, 32'h0001_0000);
    a_req = 1'b0;
    @(negedge clk);
    check_acks("ld_idle", 1'b0, 1'b0);

    // B store with address bits above and below the index set: 0x103 -> word 0.
    b_req       = 1'b1;
    b_memwrite  = 1'b1;
    b_dataadr   = 32'h0000_0103;
    b_writedata = 32'h1234_5678;
    @(negedge clk);
    check_acks("wrap_b", 1'b0, 1'b1);
    check("wrap_b_rd", b_readdata, 32'h1234_5678);
    b_req = 1'b0;
    @(negedge clk);
    check_acks("wrap_idle", 1'b0, 1'b0);
    check("wrap_mem0", dut.data[0], 32'h1234_5678);

    // Saturation from both cores: B was served last, so A, B, A, B ...
    a_req      = 1'b1;
    b_req      = 1'b1;
    a_memwrite = 1'b0;
    b_memwrite = 1'b0;
    a_dataadr  = 32'h4;
    b_dataadr  = 32'h8;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        exp_a = ((k / 2) % 2 == 0);
        check_acks("rr_ack", exp_a, !exp_a);
      end else begin
        check_acks("rr_gap", 1'b0, 1'b0);
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    check_acks("rr_done", 1'b0, 1'b0);

    // Same-word hazard: A stores, B loads word 4 in the same cycle.
    a_req       = 1'b1;
    a_memwrite  = 1'b1;
    a_dataadr   = 32'h10;
    a_writedata = 32'hDEAD_BEEF;
    b_req       = 1'b1;
    b_memwrite  = 1'b0;
    b_dataadr   = 32'h10;
    @(negedge clk);
    check_acks("haz_a", 1'b1, 1'b0);
    a_req = 1'b0;
    @(negedge clk);
    check_acks("haz_gap", 1'b0, 1'b0);
    @(negedge clk);
    check_acks("haz_b", 1'b0, 1'b1);
    check("haz_b_rd", b_readdata, 32'hDEAD_BEEF);
    b_req = 1'b0;
    @(negedge clk);
    check_acks("haz_idle", 1'b0, 1'b0);

    // Reset during A's store ack; B load of the same word pending.
    a_req       = 1'b1;
    a_memwrite  = 1'b1;
    a_dataadr   = 32'h20;
    a_writedata = 32'hCAFE_F00D;
    b_req       = 1'b1;
    b_memwrite  = 1'b0;
    b_dataadr   = 32'h20;
    @(negedge clk);
    check_acks("mid_a", 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_acks("mid_rst", 1'b0, 1'b0);
    @(negedge clk);
    check_acks("mid_rst_hold", 1'b0, 1'b0);
    check("mid_mem8", dut.data[8], 32'hCAFE_F00D);
    a_req = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check_acks("mid_b", 1'b0, 1'b1);
    check("mid_b_rd", b_readdata, 32'hCAFE_F00D);
    b_req = 1'b0;
    @(negedge clk);
    check_acks("mid_idle", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
    $finish;
  end

endmodule
